// File: rtl/clock_div_bank_pkg.sv
// Shared types and helpers for the clock divider bank: FSM states, channel
// configuration record, reset defaults and lock-counter sizing.
package clock_div_bank_pkg;

  // Internal config fields are this wide; DIVW must not exceed it.
  localparam int CFG_W       = 16;
  localparam int RST_DIV_DEF = 2;

  typedef enum logic [0:0] {
    ALIGN = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] phase;
    logic             en;
  } chan_cfg_t;

  function automatic int lock_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: active/shadow configuration, pending handshake,
// free-running counter and registered ce/sq generation.
module clock_div_chan
  import clock_div_bank_pkg::*;
#(
  parameter int RST_DIV = RST_DIV_DEF
) (
  input  logic      clkin,
  input  logic      rst_n,
  input  logic      align,
  input  logic      run,
  input  logic      wr,
  input  chan_cfg_t wr_cfg,
  output logic      ce,
  output logic      sq,
  output logic      pend_nxt,
  output logic      load
);

  localparam logic [CFG_W-1:0] ONE     = CFG_W'(1);
  localparam chan_cfg_t        RST_CFG = '{div: CFG_W'(RST_DIV), phase: {CFG_W{1'b0}}, en: 1'b1};

  chan_cfg_t        act_r, shd_r, act_nxt_s;
  logic             pend_r, wrap_s;
  logic [CFG_W-1:0] cnt_r, cnt_nxt_s, per_s, eph_s, half_s;

  // Effective period/phase, wrap detection and next counter/config state.
  always_comb begin
    per_s     = (act_r.div == {CFG_W{1'b0}}) ? ONE : act_r.div;
    eph_s     = (act_r.phase > per_s - ONE) ? per_s - ONE : act_r.phase;
    half_s    = (per_s >> 1) + CFG_W'(per_s[0]);
    wrap_s    = act_r.en && (cnt_r == per_s - ONE);
    load      = run && pend_r && (wrap_s || !act_r.en);
    pend_nxt  = pend_r;
    cnt_nxt_s = cnt_r;
    act_nxt_s = act_r;
    if (align) begin
      pend_nxt  = 1'b0;
      cnt_nxt_s = {CFG_W{1'b0}};
      if (pend_r) begin
        act_nxt_s = shd_r;
      end else begin
        act_nxt_s = act_r;
      end
    end else if (load) begin
      pend_nxt  = 1'b0;
      cnt_nxt_s = {CFG_W{1'b0}};
      act_nxt_s = shd_r;
    end else begin
      pend_nxt = pend_r | wr;
      if (!run) begin
        cnt_nxt_s = cnt_r;
      end else if (wrap_s || !act_r.en) begin
        cnt_nxt_s = {CFG_W{1'b0}};
      end else begin
        cnt_nxt_s = cnt_r + ONE;
      end
    end
  end

  // Channel state and registered outputs; ce/sq reflect the previous count.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      act_r  <= RST_CFG;
      shd_r  <= RST_CFG;
      pend_r <= 1'b0;
      cnt_r  <= {CFG_W{1'b0}};
      ce     <= 1'b0;
      sq     <= 1'b0;
    end else begin
      act_r  <= act_nxt_s;
      shd_r  <= wr ? wr_cfg : shd_r;
      pend_r <= pend_nxt;
      cnt_r  <= cnt_nxt_s;
      ce     <= run && act_r.en && (cnt_r == eph_s);
      sq     <= act_r.en && (cnt_r < half_s);
    end
  end

endmodule

// File: rtl/clock_div_bank.sv
// Bank of NCH programmable clock-enable dividers sharing one align/run FSM,
// a single configuration write port and a lock indicator.
module clock_div_bank
  import clock_div_bank_pkg::*;
#(
  parameter int NCH         = 6,
  parameter int DIVW        = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int RST_DIV     = RST_DIV_DEF
) (
  input  logic            clkin,
  input  logic            rst_n,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [3:0]      cfg_ch,
  input  logic [DIVW-1:0] cfg_div,
  input  logic [DIVW-1:0] cfg_phase,
  input  logic            cfg_en,
  input  logic            sync_req,
  output logic [NCH-1:0]  ce_out,
  output logic [NCH-1:0]  sq_out,
  output logic            cfg_err,
  output logic            locked
);

  localparam int LW = lock_w(LOCK_CYCLES);

  state_t          state_r, state_nxt_s;
  logic [LW-1:0]   lock_cnt_r;
  logic            accept_s, bad_ch_s, load_any_s, align_s, run_s;
  logic [NCH-1:0]  wr_s, pend_nxt_s, load_s;
  chan_cfg_t       wr_cfg_s;

  // Handshake, channel decode and global FSM next state.
  always_comb begin
    align_s    = (state_r == ALIGN);
    run_s      = (state_r == RUN);
    accept_s   = cfg_valid && cfg_ready;
    bad_ch_s   = ({1'b0, cfg_ch} >= 5'(NCH));
    load_any_s = |load_s;
    wr_cfg_s   = '{div: CFG_W'(cfg_div), phase: CFG_W'(cfg_phase), en: cfg_en};
    wr_s       = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      wr_s[i] = accept_s && (cfg_ch == 4'(i));
    end
    case (state_r)
      ALIGN:   state_nxt_s = RUN;
      RUN:     state_nxt_s = sync_req ? ALIGN : RUN;
      default: state_nxt_s = ALIGN;
    endcase
  end

  // FSM register, ready/error outputs and lock tracking.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ALIGN;
      cfg_ready  <= 1'b0;
      cfg_err    <= 1'b0;
      lock_cnt_r <= {LW{1'b0}};
      locked     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cfg_ready <= (state_nxt_s == RUN) && !(|pend_nxt_s);
      cfg_err   <= accept_s && bad_ch_s;
      if (!run_s || load_any_s || sync_req) begin
        lock_cnt_r <= {LW{1'b0}};
        locked     <= 1'b0;
      end else if (!locked) begin
        lock_cnt_r <= lock_cnt_r + LW'(1);
        locked     <= (lock_cnt_r == LW'(LOCK_CYCLES - 1));
      end else begin
        lock_cnt_r <= lock_cnt_r;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clock_div_chan #(
      .RST_DIV(RST_DIV)
    ) u_chan (
      .clkin   (clkin),
      .rst_n   (rst_n),
      .align   (align_s),
      .run     (run_s),
      .wr      (wr_s[g]),
      .wr_cfg  (wr_cfg_s),
      .ce      (ce_out[g]),
      .sq      (sq_out[g]),
      .pend_nxt(pend_nxt_s[g]),
      .load    (load_s[g])
    );
  end

endmodule

// File: doc/clock_div_bank.md
CLOCK_DIV_BANK -- requirements
Module: clock_div_bank

Interface
REQ-001 Parameter NCH, default 6, number of independent output channels (1..16).
REQ-002 Parameter DIVW, default 8, width of per-channel period and phase fields.
REQ-003 Parameter LOCK_CYCLES, default 16, RUN cycles without change before locked asserts (>=1).
REQ-004 Parameter RST_DIV, default 2, reset period of every channel (1..2^DIVW-1).
REQ-005 clkin  input  1  sole clock; all logic rising-edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 cfg_valid  input  1  configuration write request.
REQ-008 cfg_ready  output  1  block accepts a write this cycle.
REQ-009 cfg_ch  input  4  target channel index.
REQ-010 cfg_div  input  DIVW  channel period in clkin cycles.
REQ-011 cfg_phase  input  DIVW  count value at which the channel's ce pulse fires.
REQ-012 cfg_en  input  1  channel enable.
REQ-013 sync_req  input  1  one-cycle request to re-align all channels.
REQ-014 ce_out  output  NCH  per-channel one-cycle clock-enable pulses.
REQ-015 sq_out  output  NCH  per-channel registered square wave.
REQ-016 cfg_err  output  1  one-cycle pulse: accepted write had cfg_ch >= NCH.
REQ-017 locked  output  1  all channels aligned and stable.

Function
REQ-018 Global FSM states ALIGN, RUN; ALIGN lasts exactly one cycle, then RUN.
REQ-019 ALIGN: every counter cleared to 0, every pending shadow copied to active, locked=0, lock counter=0.
REQ-020 RUN: each enabled channel counter increments, wraps to 0 when count == period-1.
REQ-021 Effective period = cfg_div, with 0 treated as 1 (ce every cycle).
REQ-022 Effective phase = min(cfg_phase, period-1).
REQ-023 ce_out[i] = 1 for one cycle when channel enabled, state RUN, count == effective phase.
REQ-024 sq_out[i] = 1 when enabled and count < (period+1)>>1; period 1 gives constant 1.
REQ-025 Disabled channel: counter held 0, ce_out[i]=0, sq_out[i]=0.
REQ-026 Write accepted when cfg_valid & cfg_ready; data stored into channel shadow and pending flag set.
REQ-027 cfg_ready = 0 in ALIGN and while any pending flag is set.
REQ-028 In RUN, a pending channel loads shadow into active at its own wrap cycle (or next cycle if disabled), clears its pending flag, counter restarts at 0.
REQ-029 Any active-config load or sync_req clears locked and the lock counter on the next cycle.
REQ-030 locked = 1 after LOCK_CYCLES consecutive RUN cycles with no load and no sync_req; saturates.
REQ-031 sync_req in RUN -> ALIGN next cycle; sync_req during ALIGN ignored.
REQ-032 sync_req and accepted write in same cycle: write captured, then applied by the ALIGN.
REQ-033 Write with cfg_ch >= NCH: accepted, no state change, cfg_err pulses next cycle.
REQ-034 All outputs registered; ce_out/sq_out latency one cycle from counter value.

Reset
REQ-035 On rst_n low: FSM=ALIGN, counters 0, active and shadow div=RST_DIV, phase=0, en=1, pending=0.
REQ-036 During reset: ce_out=0, sq_out=0, cfg_err=0, locked=0, cfg_ready=0.
REQ-037 Reset mid-operation discards pending writes; first RUN cycle is two cycles after rst_n release.

Structure
REQ-038 Shared package holds FSM state enum, channel-config struct (div, phase, en), RST_DIV default, LOCK counter width function.
REQ-039 One sub-module clock_div_chan (counter, shadow, pending, ce/sq generation) instantiated NCH times via generate.
REQ-040 Top holds FSM, handshake, lock counter, channel decode; 120-400 RTL lines total.

Verification
REQ-041 Reset release, defaults -> ce_out all channels every 2 cycles, phase 0, locked high 16 RUN cycles later.
REQ-042 Write ch1 div=5 phase=7 -> ce_out[1] at count 4, period 5, sq_out[1] high 3 of 5 cycles, locked drops then re-asserts.
REQ-043 Write ch0 div=0 -> ce_out[0] every cycle, sq_out[0] constant 1.
REQ-044 Write ch9 with NCH=6 -> cfg_err one pulse, all outputs unchanged, locked stays high.
REQ-045 Write ch2 div=10, sync_req same cycle -> ALIGN, all counters 0 together, ch2 period 10 from first RUN cycle.
REQ-046 rst_n low while ch3 pending -> after release ch3 period 2, cfg_ready high from first RUN cycle.
